// File: rtl/inst_fetch_buffer_if.sv
// Fetch-buffer bus: the redirect request, the ROM request/response and the IF_ID handshake.
//   slave  : the fetch buffer's view (i_* inputs, o_* outputs)
//   master : the environment's view (the EX redirect source, the ROM and the IF_ID stage)
// Signal names keep the existing pipeline's i_/o_ prefixes, written from the fetch buffer's side.
interface inst_fetch_buffer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    logic              i_redirect;
    logic [ADDR_W-1:0] i_redirectPc;
    logic              o_chipEnable;
    logic [ADDR_W-1:0] o_romAddr;
    logic [INST_W-1:0] i_romInst;
    logic              o_instValid;
    logic [INST_W-1:0] o_inst;
    logic [ADDR_W-1:0] o_instPc;
    logic              i_instReady;

    modport slave (
        input  i_redirect, i_redirectPc, i_romInst, i_instReady,
        output o_chipEnable, o_romAddr, o_instValid, o_inst, o_instPc
    );

    modport master (
        output i_redirect, i_redirectPc, i_romInst, i_instReady,
        input  o_chipEnable, o_romAddr, o_instValid, o_inst, o_instPc
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch front-end between the synchronous instruction ROM and IF_ID.
// It owns the fetch PC and issues one ROM read per cycle while the buffer has credit. Returned
// instructions are queued with their PCs and presented to IF_ID through a valid/ready
// handshake. A redirect flushes both the queued fetches and the in-flight fetch, then restarts
// fetch at the new PC.
// Ports:
//   clk : clock; all state changes on the rising edge
//   rst : synchronous reset, active-high; takes priority over everything else
//   bus : inst_fetch_buffer_if.slave carrying the redirect, ROM and IF_ID signals
module inst_fetch_buffer #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input logic                  clk,
    input logic                  rst,
    inst_fetch_buffer_if.slave   bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

    logic [CntW:0]     occupancy;
    logic              issue;
    logic              push;
    logic              pop;
    logic              valid;

    // The in-flight response counts against credit, so a push into a full FIFO cannot occur.
    assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    assign issue     = !rst && !bus.i_redirect && (occupancy < (CntW + 1)'(DEPTH));
    // A response that arrives in a redirect cycle belongs to the flushed stream.
    assign push      = inflight_q && !bus.i_redirect;
    assign valid     = !rst && (count_q != '0);
    assign pop       = valid && bus.i_instReady;

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (bus.i_redirect) begin
            // A pop in this cycle is discarded along with the rest of the queue.
            pc_d     = bus.i_redirectPc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d       = pc_q + ADDR_W'(PC_STEP);
                req_pc_d   = pc_q;
                inflight_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset; count_q alone decides which entries are visible.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            inst_mem_q[wr_ptr_q] <= bus.i_romInst;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign bus.o_chipEnable = issue;
    assign bus.o_romAddr    = pc_q;
    assign bus.o_instValid  = valid;
    assign bus.o_inst       = valid ? inst_mem_q[rd_ptr_q] : '0;
    assign bus.o_instPc     = valid ? pc_mem_q[rd_ptr_q] : '0;

endmodule
